// File: rtl/instruction_fetch.sv
// picoMips instruction fetch: owns the PC, drives the synchronous ROM address,
// and holds on HEI until the synchronised, debounced SW8 reaches the requested level.
module instruction_fetch #(
   parameter int PROG_LEN    = 28,
   parameter int ADDR_W      = 5,
   parameter int INSTR_W     = 10,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4,
   parameter int OP_HEI      = 'h3E
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic [INSTR_W-1:0] Instruction,
   input  logic               SW8,
   input  logic               Stall,
   output logic [ADDR_W-1:0]  Addr,
   output logic [INSTR_W-1:0] Ir,
   output logic               IrValid,
   output logic [ADDR_W-1:0]  Pc,
   output logic               Waiting,
   output logic [1:0]         dbg_state
);

   localparam int OPC_W = INSTR_W - 4;
   localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);
   localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DEBOUNCE - 1);
   localparam logic [OPC_W-1:0]  HEI_OPC = OPC_W'(OP_HEI);

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_RUN  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      pc_q, pc_d, pc_inc;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sw_db_q, sw_db_d;
   logic [CNT_W-1:0]       db_cnt_q, db_cnt_d;
   logic                   synced;
   logic                   is_hei;
   logic                   cond_met;
   logic                   hei_unmet;

   // sync_q[0] is the metastability-exposed stage; the last stage feeds the debouncer.
   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = SW8;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   always_comb begin
      sw_db_d  = sw_db_q;
      db_cnt_d = db_cnt_q;
      if (synced == sw_db_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         sw_db_d  = ~sw_db_q;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + CNT_W'(1);
      end
   end

   // HEI operand bit names the level being left: HEI 0 waits for SW8=1, HEI 1 for SW8=0.
   assign is_hei    = (Instruction[INSTR_W-1:4] == HEI_OPC);
   assign cond_met  = (sw_db_q != Instruction[0]);
   assign hei_unmet = is_hei && !cond_met;
   assign pc_inc    = (pc_q == LAST_PC) ? '0 : pc_q + ADDR_W'(1);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      Addr    = pc_q;
      IrValid = 1'b0;
      Waiting = 1'b0;
      case (state_q)
         S_FILL: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            IrValid = !hei_unmet;
            Waiting = hei_unmet;
            if (Stall) begin
               state_d = S_RUN;
            end else if (hei_unmet) begin
               state_d = S_WAIT;
            end else begin
               Addr = pc_inc;
               pc_d = pc_inc;
            end
         end
         S_WAIT: begin
            Waiting = 1'b1;
            if (!Stall && cond_met) begin
               Addr    = pc_inc;
               pc_d    = pc_inc;
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q  <= S_FILL;
         pc_q     <= '0;
         sync_q   <= '0;
         sw_db_q  <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         sync_q   <= sync_d;
         sw_db_q  <= sw_db_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign Ir        = Instruction;
   assign Pc        = pc_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: registered ROM model plus a cycle-level reference
// model of PC sequencing, HEI blocking and SW8 debouncing.
module tb_instruction_fetch;

   localparam int PROG_LEN    = 28;
   localparam int ADDR_W      = 5;
   localparam int INSTR_W     = 10;
   localparam int SYNC_STAGES = 2;
   localparam int DEBOUNCE    = 4;
   localparam int OP_HEI      = 'h3E;

   logic               Clock = 1'b0;
   logic               Reset = 1'b1;
   logic [INSTR_W-1:0] Instruction;
   logic               SW8   = 1'b0;
   logic               Stall = 1'b0;
   logic [ADDR_W-1:0]  Addr;
   logic [INSTR_W-1:0] Ir;
   logic               IrValid;
   logic [ADDR_W-1:0]  Pc;
   logic               Waiting;
   logic [1:0]         dbg_state;

   logic [INSTR_W-1:0] rom [PROG_LEN];
   int n_checks = 0;
   int n_pass   = 0;

   int  m_pc;
   int  m_streak;
   bit  m_fill, m_block, m_db, m_unmet, m_adv;
   bit  m_raw[$];
   logic [ADDR_W-1:0]  exp_addr;
   logic [INSTR_W-1:0] exp_ir;
   logic               exp_valid, exp_wait;

   instruction_fetch #(
      .PROG_LEN(PROG_LEN), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W),
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE), .OP_HEI(OP_HEI)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Instruction(Instruction), .SW8(SW8),
      .Stall(Stall), .Addr(Addr), .Ir(Ir), .IrValid(IrValid), .Pc(Pc),
      .Waiting(Waiting), .dbg_state(dbg_state)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) begin
      if (int'(Addr) < PROG_LEN) Instruction <= rom[Addr];
      else                       Instruction <= '0;
   end

   function automatic logic [INSTR_W-1:0] hei_word(input logic b);
      logic [INSTR_W-1:0] w;
      w = '0;
      w[INSTR_W-1:4] = (INSTR_W-4)'(OP_HEI);
      w[0] = b;
      return w;
   endfunction

   function automatic bit is_hei(input logic [INSTR_W-1:0] w);
      return int'(w >> 4) == OP_HEI;
   endfunction

   task automatic fill_plain();
      logic [INSTR_W-1:0] w;
      for (int i = 0; i < PROG_LEN; i++) begin
         do w = INSTR_W'($urandom_range(0, (1 << INSTR_W) - 1)); while (is_hei(w));
         rom[i] = w;
      end
   endtask

   task automatic fill_random();
      fill_plain();
      for (int i = 0; i < PROG_LEN; i++)
         if ($urandom_range(0, 3) == 0) rom[i] = hei_word(1'($urandom_range(0, 1)));
   endtask

   function automatic void model_reset();
      m_pc = 0; m_fill = 1; m_block = 0; m_db = 0; m_streak = 0;
      m_unmet = 0; m_adv = 0;
      m_raw.delete();
      repeat (SYNC_STAGES) m_raw.push_back(1'b0);
   endfunction

   // Expected outputs for the current cycle given the inputs now applied.
   function automatic void model_eval();
      logic [INSTR_W-1:0] w;
      exp_addr = ADDR_W'(m_pc); exp_ir = 'x; exp_valid = 0; exp_wait = 0;
      m_unmet = 0; m_adv = 0;
      if (!m_fill) begin
         w = rom[m_pc];
         exp_ir    = w;
         m_unmet   = is_hei(w) && (m_db == w[0]);
         exp_wait  = m_block || m_unmet;
         exp_valid = !exp_wait;
         m_adv     = !Stall && !m_unmet;
         if (m_adv) exp_addr = ADDR_W'((m_pc + 1) % PROG_LEN);
      end
   endfunction

   function automatic void model_update();
      bit s;
      s = m_raw.pop_front();
      m_raw.push_back(SW8);
      if (s != m_db) begin
         m_streak++;
         if (m_streak == DEBOUNCE) begin
            m_db = !m_db;
            m_streak = 0;
         end
      end else begin
         m_streak = 0;
      end
      if (m_fill) m_fill = 0;
      else if (m_adv) begin
         m_pc = (m_pc + 1) % PROG_LEN;
         m_block = 0;
      end else if (m_unmet && !Stall) m_block = 1;
   endfunction

   task automatic set_in(input logic sw, input logic st);
      SW8 = sw; Stall = st;
      #1;
      model_eval();
   endtask

   task automatic tick();
      @(posedge Clock);
      if (!Reset) model_update();
      @(negedge Clock);
   endtask

   task automatic reset_assert();
      Reset = 1'b1;
      model_reset();
      #1;
   endtask

   task automatic reset_release();
      @(negedge Clock);
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      fill_plain();
      reset_assert();
      n_checks++; if (Addr !== '0)     $display("FAIL reset_addr got=%0d exp=0", Addr);        else n_pass++;
      n_checks++; if (IrValid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", IrValid);    else n_pass++;
      n_checks++; if (Waiting !== 1'b0) $display("FAIL reset_wait got=%b exp=0", Waiting);     else n_pass++;
      n_checks++; if (Pc !== '0)       $display("FAIL reset_pc got=%0d exp=0", Pc);            else n_pass++;
      reset_release();
   endtask

   task automatic test_free_run();
      int wraps = 0;
      logic [ADDR_W-1:0] prev_pc = '0;
      for (int cyc = 0; cyc < 2 * PROG_LEN + 6; cyc++) begin
         set_in(1'b0, 1'b0);
         n_checks++; if (Addr !== exp_addr)   $display("FAIL run_addr cyc=%0d got=%0d exp=%0d", cyc, Addr, exp_addr); else n_pass++;
         n_checks++; if (IrValid !== exp_valid) $display("FAIL run_valid cyc=%0d got=%b exp=%b", cyc, IrValid, exp_valid); else n_pass++;
         n_checks++; if (Pc !== ADDR_W'(m_pc)) $display("FAIL run_pc cyc=%0d got=%0d exp=%0d", cyc, Pc, m_pc); else n_pass++;
         if (!m_fill) begin
            n_checks++; if (Ir !== exp_ir) $display("FAIL run_ir cyc=%0d got=%h exp=%h", cyc, Ir, exp_ir); else n_pass++;
         end
         if (cyc > 0 && prev_pc == ADDR_W'(PROG_LEN - 1) && Pc == '0) wraps++;
         prev_pc = Pc;
         tick();
      end
      n_checks++; if (wraps != 2) $display("FAIL run_wraps got=%0d exp=2", wraps); else n_pass++;
   endtask

   task automatic test_hei_wait();
      int n = 0;
      fill_plain();
      rom[0] = hei_word(1'b0);
      reset_assert(); SW8 = 1'b0; reset_release();
      set_in(1'b0, 1'b0);
      n_checks++; if (IrValid !== 1'b0) $display("FAIL hei_fill_valid got=%b exp=0", IrValid); else n_pass++;
      tick();
      for (int cyc = 0; cyc < 20; cyc++) begin
         set_in(1'b0, 1'b0);
         n_checks++; if (Waiting !== 1'b1) $display("FAIL hei_wait cyc=%0d got=%b exp=1", cyc, Waiting); else n_pass++;
         n_checks++; if (Addr !== '0)      $display("FAIL hei_addr cyc=%0d got=%0d exp=0", cyc, Addr); else n_pass++;
         n_checks++; if (IrValid !== 1'b0) $display("FAIL hei_valid cyc=%0d got=%b exp=0", cyc, IrValid); else n_pass++;
         tick();
      end
      do begin
         set_in(1'b1, 1'b0);
         tick();
         n++;
      end while (Pc !== ADDR_W'(1) && n < 20);
      n_checks++;
      if (n != SYNC_STAGES + DEBOUNCE + 1) $display("FAIL hei_release_latency got=%0d exp=%0d", n, SYNC_STAGES + DEBOUNCE + 1);
      else n_pass++;
   endtask

   task automatic test_glitch();
      fill_plain();
      rom[0] = hei_word(1'b0);
      reset_assert(); SW8 = 1'b0; reset_release();
      repeat (6) begin set_in(1'b0, 1'b0); tick(); end
      repeat (DEBOUNCE - 1) begin set_in(1'b1, 1'b0); tick(); end
      repeat (15) begin set_in(1'b0, 1'b0); tick(); end
      set_in(1'b0, 1'b0);
      n_checks++; if (Waiting !== 1'b1) $display("FAIL glitch_wait got=%b exp=1", Waiting); else n_pass++;
      n_checks++; if (Pc !== '0)        $display("FAIL glitch_pc got=%0d exp=0", Pc); else n_pass++;
      repeat (DEBOUNCE) begin set_in(1'b1, 1'b0); tick(); end
      repeat (8) begin set_in(1'b0, 1'b0); tick(); end
      n_checks++; if (Pc !== ADDR_W'(m_pc) || m_pc != 6) $display("FAIL pulse_pc got=%0d exp=%0d", Pc, m_pc); else n_pass++;
   endtask

   task automatic test_stall();
      logic [INSTR_W-1:0] ir0;
      fill_plain();
      reset_assert(); reset_release();
      for (int k = 0; k < 40 && !(!m_fill && m_pc == 5); k++) begin set_in(1'b0, 1'b0); tick(); end
      ir0 = rom[5];
      for (int cyc = 0; cyc < 3; cyc++) begin
         set_in(1'b0, 1'b1);
         n_checks++; if (Addr !== ADDR_W'(5)) $display("FAIL stall_addr cyc=%0d got=%0d exp=5", cyc, Addr); else n_pass++;
         n_checks++; if (Pc !== ADDR_W'(5))   $display("FAIL stall_pc cyc=%0d got=%0d exp=5", cyc, Pc); else n_pass++;
         n_checks++; if (Ir !== ir0)          $display("FAIL stall_ir cyc=%0d got=%h exp=%h", cyc, Ir, ir0); else n_pass++;
         tick();
      end
      set_in(1'b0, 1'b0);
      n_checks++; if (Addr !== ADDR_W'(6)) $display("FAIL stall_release_addr got=%0d exp=6", Addr); else n_pass++;
      tick();
      n_checks++; if (Pc !== ADDR_W'(6))   $display("FAIL stall_release_pc got=%0d exp=6", Pc); else n_pass++;
   endtask

   task automatic test_back_to_back();
      fill_plain();
      rom[2] = hei_word(1'b0);
      rom[3] = hei_word(1'b1);
      reset_assert(); SW8 = 1'b0; reset_release();
      repeat (10) begin set_in(1'b0, 1'b0); tick(); end
      set_in(1'b0, 1'b0);
      n_checks++; if (Pc !== ADDR_W'(2) || Waiting !== 1'b1) $display("FAIL b2b_first pc=%0d wait=%b exp pc=2 wait=1", Pc, Waiting); else n_pass++;
      repeat (6) begin set_in(1'b1, 1'b0); tick(); end
      n_checks++; if (Pc !== ADDR_W'(2)) $display("FAIL b2b_early1 got=%0d exp=2", Pc); else n_pass++;
      set_in(1'b1, 1'b0); tick();
      n_checks++; if (Pc !== ADDR_W'(3)) $display("FAIL b2b_pass1 got=%0d exp=3", Pc); else n_pass++;
      repeat (10) begin set_in(1'b1, 1'b0); tick(); end
      set_in(1'b1, 1'b0);
      n_checks++; if (Pc !== ADDR_W'(3) || Waiting !== 1'b1) $display("FAIL b2b_second pc=%0d wait=%b exp pc=3 wait=1", Pc, Waiting); else n_pass++;
      repeat (6) begin set_in(1'b0, 1'b0); tick(); end
      n_checks++; if (Pc !== ADDR_W'(3)) $display("FAIL b2b_early2 got=%0d exp=3", Pc); else n_pass++;
      set_in(1'b0, 1'b0); tick();
      n_checks++; if (Pc !== ADDR_W'(4)) $display("FAIL b2b_pass2 got=%0d exp=4", Pc); else n_pass++;
   endtask

   task automatic test_reset_in_wait();
      fill_plain();
      rom[17] = hei_word(1'b0);
      reset_assert(); SW8 = 1'b0; reset_release();
      for (int k = 0; k < 40 && !(!m_fill && m_pc == 17); k++) begin set_in(1'b0, 1'b0); tick(); end
      repeat (3) begin set_in(1'b0, 1'b0); tick(); end
      set_in(1'b0, 1'b0);
      n_checks++; if (Pc !== ADDR_W'(17) || Waiting !== 1'b1) $display("FAIL rw_pre pc=%0d wait=%b exp pc=17 wait=1", Pc, Waiting); else n_pass++;
      reset_assert();
      n_checks++; if (Addr !== '0)      $display("FAIL rw_addr got=%0d exp=0", Addr); else n_pass++;
      n_checks++; if (IrValid !== 1'b0) $display("FAIL rw_valid got=%b exp=0", IrValid); else n_pass++;
      reset_release();
      set_in(1'b0, 1'b0);
      n_checks++; if (IrValid !== 1'b0 || Addr !== '0) $display("FAIL rw_fill valid=%b addr=%0d exp valid=0 addr=0", IrValid, Addr); else n_pass++;
      tick();
      set_in(1'b0, 1'b0);
      n_checks++; if (Pc !== '0 || IrValid !== 1'b1) $display("FAIL rw_run pc=%0d valid=%b exp pc=0 valid=1", Pc, IrValid); else n_pass++;
      n_checks++; if (Ir !== rom[0]) $display("FAIL rw_ir got=%h exp=%h", Ir, rom[0]); else n_pass++;
   endtask

   task automatic test_random();
      int   hold = 0;
      logic sw = 1'b0;
      logic st;
      fill_random();
      reset_assert(); SW8 = 1'b0; reset_release();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (hold == 0) begin
            sw   = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 12);
         end
         hold--;
         st = ($urandom_range(0, 4) == 0);
         if (cyc == 1500) begin
            reset_assert();
            n_checks++; if (Addr !== '0 || IrValid !== 1'b0) $display("FAIL rnd_reset addr=%0d valid=%b exp 0/0", Addr, IrValid); else n_pass++;
            reset_release();
         end
         set_in(sw, st);
         n_checks++; if (Addr !== exp_addr)     $display("FAIL rnd_addr cyc=%0d got=%0d exp=%0d", cyc, Addr, exp_addr); else n_pass++;
         n_checks++; if (IrValid !== exp_valid) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, IrValid, exp_valid); else n_pass++;
         n_checks++; if (Waiting !== exp_wait)  $display("FAIL rnd_wait cyc=%0d got=%b exp=%b", cyc, Waiting, exp_wait); else n_pass++;
         n_checks++; if (Pc !== ADDR_W'(m_pc))  $display("FAIL rnd_pc cyc=%0d got=%0d exp=%0d", cyc, Pc, m_pc); else n_pass++;
         if (!m_fill) begin
            n_checks++; if (Ir !== exp_ir) $display("FAIL rnd_ir cyc=%0d got=%h exp=%h", cyc, Ir, exp_ir); else n_pass++;
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_hei_wait();
      test_glitch();
      test_stall();
      test_back_to_back();
      test_reset_in_wait();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
